// File: rtl/segway_ss_seq.sv
// Power-up / soft-start sequencer for the Segway balance datapath.
// Drives pwr_up and the ss_tmr scale of the math block, derates torque
// authority on sustained overspeed, and ramps authority down on shutdown.
module segway_ss_seq #(
  parameter int         TICK_DIV     = 512,
  parameter int         OVRSPD_CNT   = 3,
  parameter logic [7:0] DERATE_FLOOR = 8'd128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_req,
  input  logic       rider_off,
  input  logic       pid_vld,
  input  logic       too_fast,
  output logic       pwr_up,
  output logic [7:0] ss_tmr,
  output logic       buzz_en,
  output logic       running
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int OW = $clog2(OVRSPD_CNT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] OVR_LIM   = OW'(OVRSPD_CNT);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    RUN,
    DERATE,
    SHUTDN
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick_cnt, tick_nxt, tick_adv;
  logic [OW-1:0] ovr_cnt, ovr_nxt, ovr_upd;
  logic [7:0]    ss_nxt, ss_inc, ss_dec;
  logic          go, tick, qual, ovr_hit;

  // Next-state, counter and scale computation.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    ovr_nxt   = ovr_cnt;
    ss_nxt    = ss_tmr;

    go       = pwr_req & ~rider_off;
    tick     = (tick_cnt == TICK_LAST);
    tick_adv = tick ? '0 : tick_cnt + TW'(1);
    ss_inc   = (ss_tmr == 8'hFF) ? 8'hFF : ss_tmr + 8'd1;
    ss_dec   = (ss_tmr == 8'h00) ? 8'h00 : ss_tmr - 8'd1;

    // In DERATE the counter tracks consecutive "not too fast" samples.
    qual = (state == DERATE) ? ~too_fast : too_fast;
    if (!pid_vld)
      ovr_upd = ovr_cnt;
    else if (!qual)
      ovr_upd = '0;
    else if (ovr_cnt == OVR_LIM)
      ovr_upd = ovr_cnt;
    else
      ovr_upd = ovr_cnt + OW'(1);
    ovr_hit = (ovr_upd == OVR_LIM);

    case (state)
      IDLE: begin
        ss_nxt   = '0;
        tick_nxt = '0;
        ovr_nxt  = '0;
        if (go)
          state_nxt = RAMP;
      end

      RAMP: begin
        if (!go)
          state_nxt = SHUTDN;
        else if (ovr_hit)
          state_nxt = DERATE;
        else begin
          ovr_nxt  = ovr_upd;
          tick_nxt = tick_adv;
          if (tick) begin
            ss_nxt = ss_inc;
            if (ss_inc == 8'hFF)
              state_nxt = RUN;
          end
        end
      end

      RUN: begin
        tick_nxt = '0;
        if (!go)
          state_nxt = SHUTDN;
        else if (ovr_hit)
          state_nxt = DERATE;
        else
          ovr_nxt = ovr_upd;
      end

      DERATE: begin
        if (!go)
          state_nxt = SHUTDN;
        else if (ovr_hit)
          state_nxt = RAMP;
        else begin
          ovr_nxt  = ovr_upd;
          tick_nxt = tick_adv;
          if (tick && (ss_tmr > DERATE_FLOOR))
            ss_nxt = ss_dec;
        end
      end

      SHUTDN: begin
        ovr_nxt = '0;
        if (go)
          state_nxt = RAMP;
        else begin
          tick_nxt = tick_adv;
          if (tick) begin
            ss_nxt = ss_dec;
            if (ss_dec == 8'h00)
              state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        ss_nxt    = '0;
      end
    endcase

    // Both counters restart on any state change, whichever branch caused it.
    if (state_nxt != state) begin
      tick_nxt = '0;
      ovr_nxt  = '0;
    end
  end

  // State, counters, scale and registered state-decoded outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      ovr_cnt  <= '0;
      ss_tmr   <= '0;
      pwr_up   <= 1'b0;
      buzz_en  <= 1'b0;
      running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      ovr_cnt  <= ovr_nxt;
      ss_tmr   <= ss_nxt;
      pwr_up   <= (state_nxt != IDLE);
      buzz_en  <= (state_nxt == DERATE);
      running  <= (state_nxt == RUN);
    end
  end

endmodule

// File: tb/tb_segway_ss_seq.sv
// Directed bench for segway_ss_seq with TICK_DIV=4, OVRSPD_CNT=3, floor 128.
// Expected outputs are queued as each step is driven and compared after it.
module tb_segway_ss_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_req;
  logic       rider_off;
  logic       pid_vld;
  logic       too_fast;
  logic       pwr_up;
  logic [7:0] ss_tmr;
  logic       buzz_en;
  logic       running;

  typedef struct {
    string       tag;
    logic [10:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  segway_ss_seq #(
    .TICK_DIV    (4),
    .OVRSPD_CNT  (3),
    .DERATE_FLOOR(8'd128)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pwr_req  (pwr_req),
    .rider_off(rider_off),
    .pid_vld  (pid_vld),
    .too_fast (too_fast),
    .pwr_up   (pwr_up),
    .ss_tmr   (ss_tmr),
    .buzz_en  (buzz_en),
    .running  (running)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: observed no summary, expected completion");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out();
    exp_t        e;
    logic [10:0] obs;
    e   = sb.pop_front();
    obs = {pwr_up, ss_tmr, buzz_en, running};
    n_total++;
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: observed pwr_up=%0b ss_tmr=%0d buzz_en=%0b running=%0b, expected pwr_up=%0b ss_tmr=%0d buzz_en=%0b running=%0b",
                e.tag, obs[10], obs[9:2], obs[1], obs[0], e.val[10], e.val[9:2], e.val[1], e.val[0]);
  endtask

  // Queue the outputs expected after n more edges, advance, then compare.
  task automatic expect_after(input int n, input string tag, input logic pu,
                              input logic [7:0] ss, input logic bz, input logic rn);
    exp_t e;
    e.tag = tag;
    e.val = {pu, ss, bz, rn};
    sb.push_back(e);
    step(n);
    check_out();
  endtask

  task automatic pulse(input logic tf);
    pid_vld  = 1'b1;
    too_fast = tf;
    step(1);
    pid_vld  = 1'b0;
    too_fast = 1'b0;
  endtask

  task automatic pulse_gap(input logic tf);
    pulse(tf);
    step(1);
  endtask

  initial begin
    rst = 1'b1; pwr_req = 1'b0; rider_off = 1'b0; pid_vld = 1'b0; too_fast = 1'b0;
    #1;
    expect_after(2, "reset", 0, 0, 0, 0);
    rst = 1'b0;

    // No power-up while the rider is off.
    pwr_req = 1'b1; rider_off = 1'b1;
    expect_after(3, "idle_rider_off", 0, 0, 0, 0);

    // Power-up ramp.
    rider_off = 1'b0;
    expect_after(1,    "pwr_up_latency",  1, 0,   0, 0);
    expect_after(3,    "ramp_pre_tick",   1, 0,   0, 0);
    expect_after(1,    "ramp_first_tick", 1, 1,   0, 0);
    expect_after(1015, "ramp_254",        1, 254, 0, 0);
    expect_after(1,    "ramp_run_1020",   1, 255, 0, 1);

    // Derate entry on the third consecutive overspeed sample.
    pulse_gap(1'b1);
    pulse_gap(1'b1);
    expect_after(0, "run_two_ovr", 1, 255, 0, 1);
    pid_vld = 1'b1; too_fast = 1'b1;
    expect_after(1, "derate_entry", 1, 255, 1, 0);
    pid_vld = 1'b0; too_fast = 1'b0;
    expect_after(507, "derate_129",   1, 129, 1, 0);
    expect_after(1,   "derate_floor", 1, 128, 1, 0);
    expect_after(20,  "derate_hold",  1, 128, 1, 0);

    // Recovery needs three consecutive clear samples.
    pulse_gap(1'b0);
    pulse_gap(1'b0);
    pulse_gap(1'b1);
    pulse_gap(1'b0);
    pulse_gap(1'b0);
    expect_after(0, "derate_partial_clear", 1, 128, 1, 0);
    pid_vld = 1'b1; too_fast = 1'b0;
    expect_after(1, "derate_exit", 1, 128, 0, 0);
    pid_vld = 1'b0;
    expect_after(3, "reramp_pre",  1, 128, 0, 0);
    expect_after(1, "reramp_tick", 1, 129, 0, 0);
    expect_after(504, "rerun", 1, 255, 0, 1);

    // Non-consecutive overspeed keeps RUN; too_fast without pid_vld ignored.
    pulse_gap(1'b1);
    pulse_gap(1'b1);
    pulse_gap(1'b0);
    pulse_gap(1'b1);
    pulse_gap(1'b1);
    expect_after(0, "nonconsec_run", 1, 255, 0, 1);
    too_fast = 1'b1;
    expect_after(5, "ignore_no_vld", 1, 255, 0, 1);
    too_fast = 1'b0;

    // Shutdown ramp and abort back to RAMP.
    pwr_req = 1'b0;
    expect_after(1,   "shutdn_entry", 1, 255, 0, 0);
    expect_after(3,   "shutdn_pre",   1, 255, 0, 0);
    expect_after(1,   "shutdn_254",   1, 254, 0, 0);
    expect_after(216, "shutdn_200",   1, 200, 0, 0);
    pwr_req = 1'b1;
    expect_after(1, "abort_ramp", 1, 200, 0, 0);
    expect_after(3, "abort_pre",  1, 200, 0, 0);
    expect_after(1, "abort_tick", 1, 201, 0, 0);

    // Shutdown wins over a simultaneous third overspeed sample and a tick.
    rst = 1'b1;
    expect_after(1, "reset_ramp", 0, 0, 0, 0);
    rst = 1'b0;
    expect_after(1,   "ramp2_entry", 1, 0,  0, 0);
    expect_after(240, "ramp2_60",    1, 60, 0, 0);
    pulse_gap(1'b1);
    pulse(1'b1);
    expect_after(0, "ramp2_two_ovr", 1, 60, 0, 0);
    pid_vld = 1'b1; too_fast = 1'b1; rider_off = 1'b1;
    expect_after(1, "simul_shutdn", 1, 60, 0, 0);
    pid_vld = 1'b0; too_fast = 1'b0;
    expect_after(239, "shutdn_1",    1, 1, 0, 0);
    expect_after(1,   "shutdn_idle", 0, 0, 0, 0);

    // Derate entered below the floor holds its level.
    rider_off = 1'b0;
    expect_after(1,   "ramp3_entry", 1, 0,  0, 0);
    expect_after(240, "ramp3_60",    1, 60, 0, 0);
    pulse_gap(1'b1);
    pulse(1'b1);
    expect_after(0, "ramp3_two_ovr", 1, 60, 0, 0);
    pid_vld = 1'b1; too_fast = 1'b1;
    expect_after(1, "derate_below_floor", 1, 60, 1, 0);
    pid_vld = 1'b0; too_fast = 1'b0;
    expect_after(40, "derate_hold_60", 1, 60, 1, 0);

    // Reset mid-DERATE.
    rst = 1'b1;
    expect_after(1, "reset_mid", 0, 0, 0, 0);
    pwr_req = 1'b0;
    rst = 1'b0;
    expect_after(2, "post_reset_idle", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
